// File: rtl/spi_slave_cs.sv
// SPI responder with chip select; all pins are synchronized into i_Clk and SCK edges are detected in-domain.
// Optional: define SPI_SLAVE_MISO_TRISTATE_EN to release MISO (1'bz) outside LOAD/SHIFT; otherwise it idles at 0.
module spi_slave_cs #(
  parameter int         SPI_MODE         = 0,
  parameter int         MAX_BYTES_PER_CS = 2,
  parameter logic [7:0] DEFAULT_TX       = 8'hFF
) (
  input  logic                                    i_Clk,
  input  logic                                    i_Rst_L,
  input  logic [7:0]                              i_TX_Byte,
  input  logic                                    i_TX_DV,
  output logic                                    o_TX_Ready,
  output logic                                    o_RX_DV,
  output logic [7:0]                              o_RX_Byte,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0]   o_RX_Count,
  output logic                                    o_Frame_Done,
  output logic                                    o_Frame_Abort,
  input  logic                                    i_SPI_Clk,
  input  logic                                    i_SPI_CS_n,
  input  logic                                    i_SPI_MOSI,
  output logic                                    o_SPI_MISO,
  output logic [1:0]                              o_Dbg_State
);

  localparam logic [1:0]    MODE    = 2'(SPI_MODE);
  localparam logic          CPOL    = MODE[1];
  localparam logic          CPHA    = MODE[0];
  localparam int            CW      = $clog2(MAX_BYTES_PER_CS + 1);
  localparam logic [CW-1:0] MAX_IDX = CW'(MAX_BYTES_PER_CS);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_END} state_t;

  state_t        state;
  logic          sck_s1, sck_s2, sck_r, sck_prev;
  logic          cs_s1, cs_s2, cs_r;
  logic          mosi_s1, mosi_s2, mosi_r;
  logic          armed;
  logic [2:0]    bit_cnt;
  logic [6:0]    rx_sr;
  logic [7:0]    tx_sr;
  logic [7:0]    hold;
  logic          need_reload;
  logic [CW-1:0] byte_idx;
  logic          miso_r;
  logic          miso_oe;

  logic       sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic [7:0] next_tx;

  // CS_n synchronizer resets to "asserted" so a reset taken mid-frame cannot
  // arm a new frame until the pin is genuinely seen high afterwards.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_s1   <= CPOL;
      sck_s2   <= CPOL;
      sck_r    <= CPOL;
      sck_prev <= CPOL;
      cs_s1    <= 1'b0;
      cs_s2    <= 1'b0;
      cs_r     <= 1'b0;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      mosi_r   <= 1'b0;
    end else begin
      sck_s1   <= i_SPI_Clk;
      sck_s2   <= sck_s1;
      sck_r    <= sck_s2;
      sck_prev <= sck_r;
      cs_s1    <= i_SPI_CS_n;
      cs_s2    <= cs_s1;
      cs_r     <= cs_s2;
      mosi_s1  <= i_SPI_MOSI;
      mosi_s2  <= mosi_s1;
      mosi_r   <= mosi_s2;
    end
  end

  assign sck_rise    = sck_r & ~sck_prev;
  assign sck_fall    = ~sck_r & sck_prev;
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  // Pending byte wins; an empty holding register lets a same-cycle i_TX_DV bypass straight in.
  assign next_tx = !o_TX_Ready ? hold : (i_TX_DV ? i_TX_Byte : DEFAULT_TX);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= ST_IDLE;
      armed         <= 1'b0;
      bit_cnt       <= 3'd0;
      rx_sr         <= 7'd0;
      tx_sr         <= DEFAULT_TX;
      hold          <= 8'd0;
      need_reload   <= 1'b0;
      byte_idx      <= '0;
      miso_r        <= 1'b0;
      miso_oe       <= 1'b0;
      o_TX_Ready    <= 1'b1;
      o_RX_DV       <= 1'b0;
      o_RX_Byte     <= 8'd0;
      o_RX_Count    <= '0;
      o_Frame_Done  <= 1'b0;
      o_Frame_Abort <= 1'b0;
    end else begin
      o_RX_DV       <= 1'b0;
      o_Frame_Done  <= 1'b0;
      o_Frame_Abort <= 1'b0;
      if (cs_r) armed <= 1'b1;
      if (i_TX_DV && o_TX_Ready) begin
        hold       <= i_TX_Byte;
        o_TX_Ready <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          bit_cnt <= 3'd0;
          miso_r  <= 1'b0;
          miso_oe <= 1'b0;
          if (!cs_r && armed) state <= ST_LOAD;
        end
        ST_LOAD: begin
          tx_sr       <= next_tx;
          o_TX_Ready  <= 1'b1;
          miso_r      <= next_tx[7];
          miso_oe     <= 1'b1;
          byte_idx    <= '0;
          bit_cnt     <= 3'd0;
          need_reload <= 1'b0;
          armed       <= 1'b0;
          state       <= cs_r ? ST_END : ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cs_r) begin
            state <= ST_END;
          end else if (sample_edge) begin
            rx_sr   <= {rx_sr[5:0], mosi_r};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              o_RX_Byte   <= {rx_sr, mosi_r};
              o_RX_DV     <= 1'b1;
              o_RX_Count  <= byte_idx;
              need_reload <= 1'b1;
              if (byte_idx != MAX_IDX) byte_idx <= byte_idx + CW'(1);
            end
          end else if (shift_edge) begin
            // The next byte is fetched on the first shift edge after a byte boundary,
            // leaving the host a few cycles after o_RX_DV to queue the next response.
            if (need_reload) begin
              tx_sr       <= next_tx;
              o_TX_Ready  <= 1'b1;
              miso_r      <= next_tx[7];
              need_reload <= 1'b0;
            end else begin
              miso_r <= tx_sr[3'd7 - bit_cnt];
            end
          end
        end
        ST_END: begin
          o_Frame_Done  <= 1'b1;
          o_Frame_Abort <= (bit_cnt != 3'd0);
          need_reload   <= 1'b0;
          miso_r        <= 1'b0;
          miso_oe       <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign o_SPI_MISO = miso_oe ? miso_r : 1'bz;
`else
  assign o_SPI_MISO = miso_r & miso_oe;
`endif

  assign o_Dbg_State = state;

endmodule

// File: tb/tb_spi_slave_cs.sv
// Bench for spi_slave_cs: one instance per SPI mode, a pin-level SPI master and a frame-level reference model.
module tb_spi_slave_cs;

  localparam int MAX = 2;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [3:0] sck, cs_n, tx_dv, tx_ready, rx_dv, done, abort, miso;
  logic       mosi;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte [4];
  logic [1:0] rx_count [4];
  logic [1:0] dbg [4];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave_cs #(.SPI_MODE(m), .MAX_BYTES_PER_CS(MAX), .DEFAULT_TX(8'hFF)) u_dut (
      .i_Clk(clk), .i_Rst_L(rst_l),
      .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv[m]), .o_TX_Ready(tx_ready[m]),
      .o_RX_DV(rx_dv[m]), .o_RX_Byte(rx_byte[m]), .o_RX_Count(rx_count[m]),
      .o_Frame_Done(done[m]), .o_Frame_Abort(abort[m]),
      .i_SPI_Clk(sck[m]), .i_SPI_CS_n(cs_n[m]), .i_SPI_MOSI(mosi),
      .o_SPI_MISO(miso[m]), .o_Dbg_State(dbg[m])
    );
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cur      = 0;
  int         h        = 6;
  logic       miso_idle;
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [7:0] exp_miso_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int         done_cnt = 0, abort_cnt = 0, abort_wo_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (rst_l) begin
      if (rx_dv[cur]) got_q.push_back({rx_count[cur], rx_byte[cur]});
      if (done[cur]) done_cnt++;
      if (abort[cur]) abort_cnt++;
      if (abort[cur] && !done[cur]) abort_wo_done++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] b);
    tx_byte = b;
    tx_dv[cur] = 1'b1;
    tick(1);
    tx_dv[cur] = 1'b0;
    tick(1);
  endtask

  // Reference: byte i of a frame reports index min(i, MAX).
  task automatic build_exp(input int nbytes);
    for (int i = 0; i < nbytes; i++)
      exp_q.push_back({((i < MAX) ? 2'(i) : 2'(MAX)), m_tx[i]});
  endtask

  task automatic frame_begin();
    logic [1:0] md;
    logic [7:0] first;
    md = 2'(cur);
    first = m_tx[0];
    cs_n[cur] = 1'b0;
    if (!md[0]) mosi = first[7];
    tick(8);
  endtask

  task automatic shift_bits(input int nbits);
    logic [1:0] md;
    logic [7:0] acc;
    logic [7:0] cb;
    logic       cpol;
    md   = 2'(cur);
    cpol = md[1];
    acc  = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      cb = m_tx[i / 8];
      if (!md[0]) begin
        acc = {acc[6:0], miso[cur]};
        sck[cur] = ~cpol;
        tick(h);
        sck[cur] = cpol;
        if (i + 1 < nbits) begin
          cb = m_tx[(i + 1) / 8];
          mosi = cb[7 - ((i + 1) % 8)];
        end
        tick(h);
      end else begin
        sck[cur] = ~cpol;
        mosi = cb[7 - (i % 8)];
        tick(h);
        acc = {acc[6:0], miso[cur]};
        sck[cur] = cpol;
        tick(h);
      end
      if ((i % 8) == 7) m_rx.push_back(acc);
    end
  endtask

  task automatic frame_end();
    cs_n[cur] = 1'b1;
    tick(10);
  endtask

  task automatic run_frame(input int nbits);
    h = $urandom_range(5, 8);
    frame_begin();
    shift_bits(nbits);
    frame_end();
  endtask

  task automatic check_frame(input logic exp_abort);
    check("rx_dv_pulses", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("rx_count_byte", {22'd0, got_q[i]}, {22'd0, exp_q[i]});
    check("miso_bytes", m_rx.size(), exp_miso_q.size());
    for (int i = 0; i < exp_miso_q.size() && i < m_rx.size(); i++)
      check("miso_byte", {24'd0, m_rx[i]}, {24'd0, exp_miso_q[i]});
    check("frame_done", done_cnt, 1);
    check("frame_abort", abort_cnt, {31'd0, exp_abort});
    check("abort_without_done", abort_wo_done, 0);
    check("miso_idle", {31'd0, miso[cur]}, {31'd0, miso_idle});
    got_q.delete(); exp_q.delete(); m_rx.delete(); exp_miso_q.delete();
    done_cnt = 0; abort_cnt = 0; abort_wo_done = 0;
  endtask

  initial begin
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    miso_idle = 1'bz;
`else
    miso_idle = 1'b0;
`endif
    rst_l = 1'b0; cs_n = 4'b1111; sck = 4'b1100; mosi = 1'b0; tx_byte = 8'd0; tx_dv = 4'd0;
    tick(3);
    rst_l = 1'b1;
    tick(5);

    for (int m = 0; m < 4; m++) begin
      check("rst_tx_ready", tx_ready[m], 1);
      check("rst_rx_dv", rx_dv[m], 0);
      check("rst_rx_byte", rx_byte[m], 0);
      check("rst_rx_count", rx_count[m], 0);
      check("rst_done_abort", {done[m], abort[m]}, 0);
      check("rst_miso", {31'd0, miso[m]}, {31'd0, miso_idle});
    end

    // Mode 0, single byte with preload.
    cur = 0;
    preload(8'hA5);
    check("tx_ready_after_preload", tx_ready[0], 0);
    m_tx = {8'h3C}; exp_miso_q = {8'hA5}; build_exp(1);
    run_frame(8);
    check_frame(1'b0);
    check("tx_ready_consumed", tx_ready[0], 1);

    // No preload: default byte goes out.
    m_tx = {8'h55}; exp_miso_q = {8'hFF}; build_exp(1);
    run_frame(8);
    check_frame(1'b0);
    check("tx_ready_no_preload", tx_ready[0], 1);

    // Partial byte, then a clean frame.
    m_tx = {8'hB6};
    run_frame(5);
    check_frame(1'b1);
    m_tx = {8'hC3}; exp_miso_q = {8'hFF}; build_exp(1);
    run_frame(8);
    check_frame(1'b0);

    // Byte index saturation.
    m_tx = {8'h11, 8'h22, 8'h33, 8'h44}; exp_miso_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF}; build_exp(4);
    run_frame(32);
    check_frame(1'b0);

    // Modes 1..3: two-byte frame, second response queued after the first o_RX_DV.
    for (int m = 1; m < 4; m++) begin
      cur = m;
      preload(8'h81);
      m_tx = {8'h12, 8'h34}; exp_miso_q = {8'h81, 8'h7E}; build_exp(2);
      h = $urandom_range(5, 8);
      frame_begin();
      fork
        shift_bits(16);
        begin
          int k;
          k = 0;
          while (!rx_dv[cur] && k < 400) begin
            @(negedge clk);
            k++;
          end
          check("first_rx_dv_seen", {31'd0, (k < 400)}, 1);
          tx_byte = 8'h7E;
          tx_dv[cur] = 1'b1;
          tick(1);
          tx_dv[cur] = 1'b0;
        end
      join
      frame_end();
      check_frame(1'b0);
      check("tx_ready_two_byte", tx_ready[m], 1);
    end

    // Random frames in every mode, optional random preload.
    for (int m = 0; m < 4; m++) begin
      int nb;
      logic [7:0] pb;
      cur = m;
      nb = $urandom_range(1, 3);
      m_tx.delete();
      for (int i = 0; i < nb; i++) m_tx.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        pb = 8'($urandom);
        preload(pb);
      end else begin
        pb = 8'hFF;
      end
      exp_miso_q.push_back(pb);
      for (int i = 1; i < nb; i++) exp_miso_q.push_back(8'hFF);
      build_exp(nb);
      run_frame(nb * 8);
      check_frame(1'b0);
    end

    // Reset mid-byte.
    cur = 0;
    m_tx = {8'h77};
    h = 6;
    frame_begin();
    shift_bits(5);
    preload(8'h5A);
    check("tx_ready_hold_mid", tx_ready[0], 0);
    #2 rst_l = 1'b0;
    #1;
    check("midrst_tx_ready", tx_ready[0], 1);
    check("midrst_rx_dv", rx_dv[0], 0);
    check("midrst_rx_byte", rx_byte[0], 0);
    check("midrst_rx_count", rx_count[0], 0);
    check("midrst_done_abort", {done[0], abort[0]}, 0);
    check("midrst_miso", {31'd0, miso[0]}, {31'd0, miso_idle});
    tick(3);
    rst_l = 1'b1;
    tick(2);
    m_tx = {8'hE7};
    shift_bits(8);
    cs_n[0] = 1'b1;
    tick(10);
    check("no_rx_after_rst", got_q.size(), 0);
    check("no_done_after_rst", done_cnt, 0);
    check("miso_idle_cs_high", {31'd0, miso[0]}, {31'd0, miso_idle});
    m_rx.delete(); got_q.delete(); done_cnt = 0; abort_cnt = 0; abort_wo_done = 0;
    m_tx = {8'h99}; exp_miso_q = {8'hFF}; build_exp(1);
    run_frame(8);
    check_frame(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
